// File: rtl/joy_drp_pkg.sv
// joy_drp_pkg: shared addresses, config bit position and FSM states for the joystick DRP responder
package joy_drp_pkg;
   localparam logic [6:0] DEF_CH_X_ADDR = 7'h16;
   localparam logic [6:0] DEF_CH_Y_ADDR = 7'h17;
   localparam logic [6:0] DEF_CFG_ADDR = 7'h40;
   localparam int CFG_FREEZE_BIT = 0;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/joy_drp_if.sv
// joy_drp_if: DRP request/response bundle between initiator (master) and responder (slave)
interface joy_drp_if;
   logic den_in;
   logic dwe_in;
   logic [6:0] daddr_in;
   logic [15:0] di_in;
   logic [15:0] do_out;
   logic drdy_out;
   logic busy_out;
   logic req_dropped;
   modport master (output den_in, dwe_in, daddr_in, di_in, input do_out, drdy_out, busy_out, req_dropped);
   modport slave (input den_in, dwe_in, daddr_in, di_in, output do_out, drdy_out, busy_out, req_dropped);
endinterface

// File: rtl/joy_drp_avg4.sv
// joy_drp_avg4: 4-sample moving average over a shift history that resets to zero
module joy_drp_avg4 (
   input logic clk_1MHz,
   input logic rst_n,
   input logic en,
   input logic [11:0] din,
   output logic [11:0] avg
);
   logic [11:0] h [4];
   logic [13:0] sum;
   always_ff @(posedge clk_1MHz or negedge rst_n)
      if (!rst_n) h <= '{default: '0};
      else if (en) h <= '{din, h[0], h[1], h[2]};
   assign sum = {2'b0, h[0]} + {2'b0, h[1]} + {2'b0, h[2]} + {2'b0, h[3]};
   assign avg = 12'(sum >> 2);
endmodule

// File: rtl/joy_drp_responder.sv
// joy_drp_responder: XADC-style DRP responder for joystick X/Y samples; JOY_DRP_AVG_EN enables 4-sample averaging
module joy_drp_responder
   import joy_drp_pkg::*;
#(
   parameter int RD_LATENCY = 4,
   parameter logic [6:0] CH_X_ADDR = DEF_CH_X_ADDR,
   parameter logic [6:0] CH_Y_ADDR = DEF_CH_Y_ADDR,
   parameter logic [6:0] CFG_ADDR = DEF_CFG_ADDR
) (
   input logic clk_1MHz,
   input logic rst_n,
   input logic sample_valid,
   input logic sample_ch,
   input logic [11:0] sample_data,
   output logic eoc_out,
   output logic [6:0] channel_out,
   joy_drp_if.slave drp
);
   localparam logic [3:0] LAST = 4'(RD_LATENCY - 1);
   state_t state, state_n;
   logic [3:0] cnt;
   logic [15:0] cfg, snap, rd_data;
   logic [11:0] x_val, y_val;
   logic upd, upd_x, upd_y, accept;
   assign upd = sample_valid & ~cfg[CFG_FREEZE_BIT];
   assign upd_x = upd & ~sample_ch;
   assign upd_y = upd & sample_ch;
   assign accept = (state == IDLE) & drp.den_in;
   // snapshot sees pre-edge register values, so a same-cycle sample update is not visible
   assign rd_data = drp.dwe_in ? '0 :
                    drp.daddr_in == CH_X_ADDR ? {x_val, 4'h0} :
                    drp.daddr_in == CH_Y_ADDR ? {y_val, 4'h0} :
                    drp.daddr_in == CFG_ADDR ? cfg : '0;
   always_ff @(posedge clk_1MHz or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      drp.busy_out = state != IDLE;
      drp.drdy_out = state == RESP;
      drp.do_out = state == RESP ? snap : '0;
      state_n = state == IDLE ? (drp.den_in ? WAIT : IDLE) :
                state == WAIT ? (cnt == LAST ? RESP : WAIT) : IDLE;
   end
   always_ff @(posedge clk_1MHz or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         snap <= '0;
         cfg <= '0;
         drp.req_dropped <= 1'b0;
         eoc_out <= 1'b0;
         channel_out <= '0;
      end else begin
         cnt <= accept ? 4'd1 : cnt + 4'd1;
         if (accept) snap <= rd_data;
         if (accept && drp.dwe_in && drp.daddr_in == CFG_ADDR) cfg <= drp.di_in;
         drp.req_dropped <= drp.den_in & drp.busy_out;
         eoc_out <= upd;
         if (upd) channel_out <= sample_ch ? CH_Y_ADDR : CH_X_ADDR;
      end
`ifdef JOY_DRP_AVG_EN
   joy_drp_avg4 u_avg_x (.clk_1MHz(clk_1MHz), .rst_n(rst_n), .en(upd_x), .din(sample_data), .avg(x_val));
   joy_drp_avg4 u_avg_y (.clk_1MHz(clk_1MHz), .rst_n(rst_n), .en(upd_y), .din(sample_data), .avg(y_val));
`else
   always_ff @(posedge clk_1MHz or negedge rst_n)
      if (!rst_n) begin
         x_val <= '0;
         y_val <= '0;
      end else begin
         if (upd_x) x_val <= sample_data;
         if (upd_y) y_val <= sample_data;
      end
`endif
endmodule

// File: tb/tb_joy_drp_responder.sv
// tb_joy_drp_responder: random and directed DRP/sample traffic checked against a cycle-level scoreboard model
module tb_joy_drp_responder;
   localparam int L = 4;
   typedef struct {int cyc; logic [15:0] d;} ev_t;
   logic clk_1MHz = 0, rst_n = 0;
   logic sample_valid = 0, sample_ch = 0;
   logic [11:0] sample_data = 0;
   logic eoc_out;
   logic [6:0] channel_out;
   joy_drp_if drp();
   joy_drp_responder dut (
      .clk_1MHz(clk_1MHz), .rst_n(rst_n), .sample_valid(sample_valid), .sample_ch(sample_ch),
      .sample_data(sample_data), .eoc_out(eoc_out), .channel_out(channel_out), .drp(drp.slave)
   );
   always #500 clk_1MHz = ~clk_1MHz;
   int total = 0, bad = 0, cyc = 0, last_acc = 0;
   bit acc_valid = 0;
   ev_t rq[$], eq[$];
   int dq[$];
   logic [11:0] m_x = 0, m_y = 0;
   logic [15:0] m_cfg = 0;
   int hx[4] = '{0, 0, 0, 0}, hy[4] = '{0, 0, 0, 0};
   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", n, cyc, a, e);
      end
   endtask
   function automatic logic [15:0] m_rd(input logic [6:0] a);
      return a == 7'h16 ? {m_x, 4'h0} : a == 7'h17 ? {m_y, 4'h0} : a == 7'h40 ? m_cfg : 16'h0;
   endfunction
   task automatic m_clear();
      rq.delete(); eq.delete(); dq.delete();
      m_x = 0; m_y = 0; m_cfg = 0; acc_valid = 0;
      hx = '{0, 0, 0, 0}; hy = '{0, 0, 0, 0};
   endtask
   task automatic step(input logic sv, input logic ch, input logic [11:0] sd, input logic den,
                       input logic dwe, input logic [6:0] a, input logic [15:0] di);
      logic [15:0] cfg_n;
      @(posedge clk_1MHz); #1;
      cyc++;
      sample_valid = sv; sample_ch = ch; sample_data = sd;
      drp.den_in = den; drp.dwe_in = dwe; drp.daddr_in = a; drp.di_in = di;
      cfg_n = m_cfg;
      if (den) begin
         if (acc_valid && cyc <= last_acc + L) dq.push_back(cyc + 1);
         else begin
            acc_valid = 1; last_acc = cyc;
            rq.push_back('{cyc + L, dwe ? 16'h0 : m_rd(a)});
            if (dwe && a == 7'h40) cfg_n = di;
         end
      end
      if (sv && !m_cfg[0]) begin
`ifdef JOY_DRP_AVG_EN
         if (ch) begin hy = '{int'(sd), hy[0], hy[1], hy[2]}; m_y = 12'((hy[0] + hy[1] + hy[2] + hy[3]) / 4); end
         else begin hx = '{int'(sd), hx[0], hx[1], hx[2]}; m_x = 12'((hx[0] + hx[1] + hx[2] + hx[3]) / 4); end
`else
         if (ch) m_y = sd; else m_x = sd;
`endif
         eq.push_back('{cyc + 1, ch ? 16'h17 : 16'h16});
      end
      m_cfg = cfg_n;
   endtask
   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic rd(input logic [6:0] a);
      step(0, 0, 0, 1, 0, a, 0);
   endtask
   task automatic wr(input logic [6:0] a, input logic [15:0] di);
      step(0, 0, 0, 1, 1, a, di);
   endtask
   always @(negedge clk_1MHz) begin
      bit e;
      if (!rst_n) begin
         chk("rst_drdy", {15'b0, drp.drdy_out}, 0);
         chk("rst_busy", {15'b0, drp.busy_out}, 0);
         chk("rst_do", drp.do_out, 0);
         chk("rst_eoc", {15'b0, eoc_out}, 0);
         chk("rst_channel", {9'b0, channel_out}, 0);
         chk("rst_dropped", {15'b0, drp.req_dropped}, 0);
      end else begin
         while (rq.size() != 0 && rq[0].cyc < cyc) begin chk("drdy_overdue", 1, 0); void'(rq.pop_front()); end
         e = rq.size() != 0 && rq[0].cyc == cyc;
         chk("drdy", {15'b0, drp.drdy_out}, {15'b0, e});
         if (e) begin chk("do_out", drp.do_out, rq[0].d); void'(rq.pop_front()); end
         e = eq.size() != 0 && eq[0].cyc == cyc;
         chk("eoc", {15'b0, eoc_out}, {15'b0, e});
         if (e) begin chk("channel", {9'b0, channel_out}, eq[0].d); void'(eq.pop_front()); end
         while (eq.size() != 0 && eq[0].cyc < cyc) void'(eq.pop_front());
         e = dq.size() != 0 && dq[0] == cyc;
         chk("req_dropped", {15'b0, drp.req_dropped}, {15'b0, e});
         if (e) void'(dq.pop_front());
         while (dq.size() != 0 && dq[0] < cyc) void'(dq.pop_front());
         e = acc_valid && cyc >= last_acc + 1 && cyc <= last_acc + L;
         chk("busy", {15'b0, drp.busy_out}, {15'b0, e});
      end
   end
   initial begin
      drp.den_in = 0; drp.dwe_in = 0; drp.daddr_in = 0; drp.di_in = 0;
      repeat (3) @(posedge clk_1MHz);
      #1 rst_n = 1;
      step(1, 0, 12'hABC, 0, 0, 0, 0);
      rd(7'h16); idle(6);
      rd(7'h16); idle(1); rd(7'h16); idle(5);
      wr(7'h40, 16'h0001); step(1, 1, 12'h123, 0, 0, 0, 0); idle(5);
      rd(7'h17); idle(5); rd(7'h40); idle(5); wr(7'h40, 16'h0000); idle(5);
      rd(7'h20); idle(5); wr(7'h16, 16'hFFFF); idle(5); rd(7'h16); idle(5);
      rd(7'h16); idle(1);
      @(posedge clk_1MHz); #1 rst_n = 0; cyc++;
      #1;
      chk("async_drdy", {15'b0, drp.drdy_out}, 0);
      chk("async_busy", {15'b0, drp.busy_out}, 0);
      chk("async_do", drp.do_out, 0);
      m_clear();
      drp.den_in = 0;
      repeat (2) begin @(posedge clk_1MHz); #1 cyc++; end
      rst_n = 1;
      idle(8);
      step(1, 0, 12'd400, 0, 0, 0, 0); step(1, 0, 12'd800, 0, 0, 0, 0);
      step(1, 0, 12'd1200, 0, 0, 0, 0); step(1, 0, 12'd1600, 0, 0, 0, 0);
      rd(7'h16); idle(5);
      for (int i = 0; i < 2000; i++) begin
         logic [6:0] a;
         int s;
         s = $urandom_range(0, 3);
         a = s == 0 ? 7'h16 : s == 1 ? 7'h17 : s == 2 ? 7'h40 : 7'($urandom);
         step($urandom_range(0, 9) < 3, 1'($urandom), 12'($urandom), $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 3, a, 16'($urandom));
      end
      idle(10);
      chk("resp_queue_empty", 16'(rq.size()), 0);
      chk("eoc_queue_empty", 16'(eq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #50ms;
      $display("FAIL timeout cycle=%0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
